// File: rtl/bc_horner_if.sv
// Control bundle between the Horner sequencer (slave side) and its host/datapath (master side).
interface bc_horner_if;
  logic       start;
  logic       Overflow;
  logic       LX;
  logic       LS;
  logic       LH;
  logic       H;
  logic [1:0] M0;
  logic [1:0] M1;
  logic [1:0] M2;
  logic       busy;
  logic       done;
  logic       ovf;

  modport master (
    output start, Overflow,
    input  LX, LS, LH, H, M0, M1, M2, busy, done, ovf
  );

  modport slave (
    input  start, Overflow,
    output LX, LS, LH, H, M0, M1, M2, busy, done, ovf
  );
endinterface

// File: rtl/bc_horner.sv
// Moore sequencer driving an external ALU datapath to evaluate A*X^2 + B*X + C by Horner's rule.
// Control outputs are registered from the next-state decode, so they track the state register exactly.
module bc_horner #(
  parameter logic H_ADD = 1'b0,
  parameter logic H_MUL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  bc_horner_if.slave bus
);

  localparam int unsigned ST_W  = 4;
  localparam int unsigned MUX_W = 2;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_LDX  = 4'd1;
  localparam logic [3:0] S_CLRH = 4'd2;
  localparam logic [3:0] S_LDA  = 4'd3;
  localparam logic [3:0] S_MUL1 = 4'd4;
  localparam logic [3:0] S_ADDB = 4'd5;
  localparam logic [3:0] S_MUL2 = 4'd6;
  localparam logic [3:0] S_ADDC = 4'd7;
  localparam logic [3:0] S_DONE = 4'd8;

  localparam logic [MUX_W-1:0] M0_ZERO = 2'b00;
  localparam logic [MUX_W-1:0] M0_A    = 2'b01;
  localparam logic [MUX_W-1:0] M0_B    = 2'b10;
  localparam logic [MUX_W-1:0] M0_C    = 2'b11;
  localparam logic [MUX_W-1:0] M1_M0   = 2'b00;
  localparam logic [MUX_W-1:0] M1_RX   = 2'b01;
  localparam logic [MUX_W-1:0] M1_RH   = 2'b11;
  localparam logic [MUX_W-1:0] M2_RX   = 2'b00;
  localparam logic [MUX_W-1:0] M2_M0   = 2'b01;
  localparam logic [MUX_W-1:0] M2_RS   = 2'b10;

  logic [ST_W-1:0]  r_state;
  logic [ST_W-1:0]  w_state_nxt;

  logic             r_lx;
  logic             r_ls;
  logic             r_lh;
  logic             r_h;
  logic [MUX_W-1:0] r_m0;
  logic [MUX_W-1:0] r_m1;
  logic [MUX_W-1:0] r_m2;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;

  logic             w_lx;
  logic             w_ls;
  logic             w_lh;
  logic             w_h;
  logic [MUX_W-1:0] w_m0;
  logic [MUX_W-1:0] w_m1;
  logic [MUX_W-1:0] w_m2;
  logic             w_busy;
  logic             w_done;
  logic             w_ovf_nxt;

  // Next state, control decode of that state, and sticky overflow update
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_LDX;
      S_LDX:   w_state_nxt = S_CLRH;
      S_CLRH:  w_state_nxt = S_LDA;
      S_LDA:   w_state_nxt = S_MUL1;
      S_MUL1:  w_state_nxt = S_ADDB;
      S_ADDB:  w_state_nxt = S_MUL2;
      S_MUL2:  w_state_nxt = S_ADDC;
      S_ADDC:  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_lx   = 1'b0;
    w_ls   = 1'b0;
    w_lh   = 1'b0;
    w_h    = H_ADD;
    w_m0   = M0_ZERO;
    w_m1   = M1_M0;
    w_m2   = M2_RX;
    w_done = 1'b0;
    w_busy = (w_state_nxt != S_IDLE);
    case (w_state_nxt)
      S_LDX:  w_lx = 1'b1;
      S_CLRH: begin
        w_lh = 1'b1;
        w_m2 = M2_M0;
      end
      S_LDA: begin
        w_ls = 1'b1;
        w_m0 = M0_A;
        w_m1 = M1_RH;
        w_m2 = M2_M0;
      end
      S_MUL1, S_MUL2: begin
        w_ls = 1'b1;
        w_h  = H_MUL;
        w_m1 = M1_RX;
        w_m2 = M2_RS;
      end
      S_ADDB: begin
        w_ls = 1'b1;
        w_m0 = M0_B;
        w_m2 = M2_RS;
      end
      S_ADDC: begin
        w_ls = 1'b1;
        w_m0 = M0_C;
        w_m2 = M2_RS;
      end
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase

    // Overflow is qualified by the LS currently being presented to the datapath
    w_ovf_nxt = r_ovf;
    if ((r_state == S_IDLE) && (w_state_nxt == S_LDX)) begin
      w_ovf_nxt = 1'b0;
    end else if (r_ls && bus.Overflow) begin
      w_ovf_nxt = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lx    <= 1'b0;
      r_ls    <= 1'b0;
      r_lh    <= 1'b0;
      r_h     <= H_ADD;
      r_m0    <= M0_ZERO;
      r_m1    <= M1_M0;
      r_m2    <= M2_RX;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lx    <= w_lx;
      r_ls    <= w_ls;
      r_lh    <= w_lh;
      r_h     <= w_h;
      r_m0    <= w_m0;
      r_m1    <= w_m1;
      r_m2    <= w_m2;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign bus.LX   = r_lx;
  assign bus.LS   = r_ls;
  assign bus.LH   = r_lh;
  assign bus.H    = r_h;
  assign bus.M0   = r_m0;
  assign bus.M1   = r_m1;
  assign bus.M2   = r_m2;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.ovf  = r_ovf;

endmodule
